// File: rtl/softmax_argmax_seq_pkg.sv
// softmax_argmax_seq shared package.
// fp32 constants, NaN test and FSM state encoding.
package softmax_argmax_seq_pkg;

   localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == FP32_EXP_MAX) && (x[22:0] != '0);
   endfunction

endpackage

// File: rtl/softmax_argmax_seq_if.sv
// softmax_argmax_seq handshake interface.
// master drives vectors in and takes results out.
interface softmax_argmax_seq_if #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
   logic             in_valid;
   logic             in_ready;
   logic [N*32-1:0]  in_vector;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_index;
   logic [31:0]      out_value;
   logic             out_all_nan;

   modport master (
      output in_valid, in_vector, out_ready,
      input  in_ready, out_valid, out_index,
      input  out_value, out_all_nan
   );

   modport slave (
      input  in_valid, in_vector, out_ready,
      output in_ready, out_valid, out_index,
      output out_value, out_all_nan
   );
endinterface

// File: rtl/softmax_argmax_seq_fp32_greater.sv
// fp32_greater: combinational float32 a > b.
// NaN never wins, a number always beats NaN, +0 == -0.
module fp32_greater
   import softmax_argmax_seq_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        a_gt_b
);
   logic a_zero;
   logic b_zero;

   assign a_zero = (a == FP32_POS_ZERO) || (a == FP32_NEG_ZERO);
   assign b_zero = (b == FP32_POS_ZERO) || (b == FP32_NEG_ZERO);

   // sign/magnitude ordering with NaN and signed-zero handling
   always_comb begin
      a_gt_b = 1'b0;
      if (is_nan(a)) begin
         a_gt_b = 1'b0;
      end else if (is_nan(b)) begin
         a_gt_b = 1'b1;
      end else if (a_zero && b_zero) begin
         a_gt_b = 1'b0;
      end else if (a[31] != b[31]) begin
         a_gt_b = b[31];
      end else if (a[31]) begin
         a_gt_b = a[30:0] < b[30:0];
      end else begin
         a_gt_b = a[30:0] > b[30:0];
      end
   end
endmodule

// File: rtl/softmax_argmax_seq.sv
// softmax_argmax_seq: sequential argmax over N float32.
// One element compared per cycle through a single comparator.
module softmax_argmax_seq
   import softmax_argmax_seq_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input logic                 clk,
   input logic                 rst,
   softmax_argmax_seq_if.slave bus
);
   state_t           state_q;
   state_t           state_d;
   logic [N*32-1:0]  vec_q;
   logic [31:0]      best_q;
   logic [IDX_W-1:0] best_idx_q;
   logic [IDX_W-1:0] cnt_q;
   logic [31:0]      elem [N];
   logic [31:0]      cur;
   logic             cur_gt;
   logic             accept;
   logic             last;

   // unpack the registered vector; element 0 sits at the MSBs
   always_comb begin
      for (int i = 0; i < N; i++) begin
         elem[i] = vec_q[(N-1-i)*32 +: 32];
      end
   end

   assign cur    = elem[cnt_q];
   assign last   = (cnt_q == IDX_W'(N - 1));
   assign accept = (state_q == IDLE) && bus.in_valid;

   fp32_greater u_cmp (
      .a      (cur),
      .b      (best_q),
      .a_gt_b (cur_gt)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and handshake outputs
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_d = (N > 1) ? SCAN : DONE;
            end
         end
         SCAN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // capture vector on accept, then keep the running maximum
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         cnt_q      <= '0;
      end else if (accept) begin
         vec_q      <= bus.in_vector;
         best_q     <= bus.in_vector[N*32-1 -: 32];
         best_idx_q <= '0;
         cnt_q      <= IDX_W'(1);
      end else if (state_q == SCAN) begin
         if (cur_gt) begin
            best_q     <= cur;
            best_idx_q <= cnt_q;
         end
         cnt_q <= cnt_q + IDX_W'(1);
      end
   end

   assign bus.out_index   = best_idx_q;
   assign bus.out_value   = best_q;
   assign bus.out_all_nan = is_nan(best_q);
endmodule

// File: tb/tb_softmax_argmax_seq.sv
// tb_softmax_argmax_seq: scoreboard bench for softmax_argmax_seq.
// Random vectors checked against a real-valued argmax model.
module tb_softmax_argmax_seq;
   localparam int N     = 4;
   localparam int IDX_W = 2;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [31:0]      val;
      logic             nan;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   exp_t q[$];

   softmax_argmax_seq_if #(.N(N), .IDX_W(IDX_W)) bus ();

   softmax_argmax_seq #(.N(N), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   function automatic real f2r(input logic [31:0] x);
      int  e;
      real m;
      real mag;
      e = int'(x[30:23]);
      m = real'(x[22:0]);
      if (e == 255)
         mag = 1.0e300;
      else if (e == 0)
         mag = m * (2.0 ** (-149));
      else
         mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
      return x[31] ? -mag : mag;
   endfunction

   function automatic exp_t model(input logic [N*32-1:0] v);
      exp_t        r;
      real         bv;
      real         x;
      bit          found;
      logic [31:0] e;
      found = 0;
      bv    = 0.0;
      r.idx = '0;
      r.val = v[N*32-1 -: 32];
      r.nan = 1'b1;
      for (int i = 0; i < N; i++) begin
         e = v[(N-1-i)*32 +: 32];
         if (e[30:23] == 8'hFF && e[22:0] != 23'h0)
            continue;
         x = f2r(e);
         if (!found || x > bv) begin
            found = 1;
            bv    = x;
            r.idx = IDX_W'(i);
            r.val = e;
            r.nan = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_elem(
         input logic [31:0] prev);
      logic        s;
      logic [22:0] m;
      s = 1'($urandom_range(0, 1));
      m = 23'($urandom);
      case ($urandom_range(0, 9))
         0: return $urandom;
         1: return {s, 8'hFF, m | 23'h1};
         2: return {s, 31'h0};
         3: return {s, 8'hFF, 23'h0};
         4: return {s, 8'h00, m};
         5: return prev;
         default:
            return {s, 8'($urandom_range(110, 140)), m};
      endcase
   endfunction

   function automatic logic [N*32-1:0] rnd_vec();
      logic [N*32-1:0] v;
      logic [31:0]     p;
      bit              all_nan;
      all_nan = ($urandom_range(0, 9) == 0);
      p = 32'h3F80_0000;
      for (int i = 0; i < N; i++) begin
         p = all_nan ? {1'($urandom), 8'hFF, 23'h40_0001}
                     : rnd_elem(p);
         v[(N-1-i)*32 +: 32] = p;
      end
      return v;
   endfunction

   function automatic logic [N*32-1:0] junk();
      logic [N*32-1:0] v;
      for (int i = 0; i < N; i++)
         v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   bit rand_rdy;

   task automatic send(input logic [N*32-1:0] v,
                       input exp_t e);
      int t;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         if (rand_rdy)
            bus.out_ready = 1'($urandom_range(0, 1));
         t++;
      end while (!bus.in_ready && t < 300);
      if (!bus.in_ready) begin
         chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      end else begin
         bus.in_valid  = 1'b1;
         bus.in_vector = v;
         @(posedge clk);
         q.push_back(e);
         #1;
         bus.in_valid  = 1'b0;
         bus.in_vector = junk();
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   // scoreboard monitor: compare on every output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 64'(bus.out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            chk("out_index", 64'(bus.out_index), 64'(e.idx));
            chk("out_value", 64'(bus.out_value), 64'(e.val));
            chk("out_all_nan", 64'(bus.out_all_nan),
                64'(e.nan));
         end
      end
   end

   initial begin
      logic [N*32-1:0] v;
      logic [IDX_W-1:0] sidx;
      logic [31:0]      sval;
      int               t;
      bit               seen;
      n_chk  = 0;
      n_fail = 0;
      rand_rdy = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_vector = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_index", 64'(bus.out_index), 64'd0);
      chk("rst_out_value", 64'(bus.out_value), 64'd0);
      chk("rst_all_nan", 64'(bus.out_all_nan), 64'd0);
      rst = 1'b0;

      bus.out_ready = 1'b1;
      send({32'h3890969E, 32'h39D53C13,
            32'h3D388CBF, 32'h3F745809},
           '{2'd3, 32'h3F745809, 1'b0});
      repeat (N-2) @(posedge clk);
      #1;
      chk("lat_early", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_cycle_n", 64'(bus.out_valid), 64'd1);

      send({32'hC0000000, 32'hBF800000,
            32'hC0800000, 32'hC0400000},
           '{2'd1, 32'hBF800000, 1'b0});
      send({32'h3F800000, 32'h3F800000,
            32'h3F000000, 32'h3E800000},
           '{2'd0, 32'h3F800000, 1'b0});
      send({32'h80000000, 32'h00000000,
            32'hBF800000, 32'hC0000000},
           '{2'd0, 32'h80000000, 1'b0});
      send({32'h7FC00000, 32'h3F000000,
            32'h7F800001, 32'h3E800000},
           '{2'd1, 32'h3F000000, 1'b0});
      send({4{32'h7FC00000}},
           '{2'd0, 32'h7FC00000, 1'b1});
      drain();

      bus.out_ready = 1'b0;
      send({32'h3E000000, 32'h40000000,
            32'h3F000000, 32'h40000000},
           '{2'd1, 32'h40000000, 1'b0});
      t = 0;
      while (!bus.out_valid && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      sidx = bus.out_index;
      sval = bus.out_value;
      v = {32'hBF000000, 32'hC0000000,
           32'h3D000000, 32'h3C000000};
      bus.in_valid  = 1'b1;
      bus.in_vector = v;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold",
             64'({bus.out_valid, bus.in_ready,
                  bus.out_index, bus.out_value}),
             64'({1'b1, 1'b0, sidx, sval}));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_no_reaccept",
          64'({bus.in_ready, bus.out_valid}),
          64'({1'b1, 1'b0}));
      @(posedge clk);
      q.push_back('{2'd2, 32'h3D000000, 1'b0});
      #1;
      chk("bp_accept_next", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b0;
      drain();

      send({32'h3F800000, 32'h40000000,
            32'h40400000, 32'h40800000},
           '{2'd3, 32'h40800000, 1'b0});
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_state",
          64'({bus.in_ready, bus.out_valid,
               bus.out_index, bus.out_value}),
          64'({1'b1, 1'b0, 2'd0, 32'h0}));
      q.delete();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < N + 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1;
      end
      chk("mid_rst_dropped", 64'(seen), 64'd0);

      rand_rdy = 1;
      for (int k = 0; k < 80; k++) begin
         v = rnd_vec();
         send(v, model(v));
      end
      rand_rdy = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/softmax_argmax_seq.md
Name: softmax_argmax_seq

Overview:
- Consumer end of the softmax interface: takes a packed vector of N IEEE-754 float32 probabilities and returns the winning class index and its value.
- Sits directly after the softmax stage as the network's classification decoder.
- Scans the vector one element per cycle to keep comparator area to a single float comparator.
- valid/ready handshakes on both sides.

Parameters:
- N, 4, number of float32 elements in the vector (N >= 1).
- IDX_W, $clog2(N) (minimum 1), width of the index output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vector holds a valid vector.
- in_ready  output  1  block can accept a vector.
- in_vector  input  N*32  packed float32; element 0 occupies bits [N*32-1 -: 32], element N-1 occupies bits [31:0].
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_index  output  IDX_W  index of the maximum element.
- out_value  output  32  float32 bits of the maximum element.
- out_all_nan  output  1  every element was NaN.

Behaviour:
- Reset: clock and reset fixed as above; rst is sampled on the clk edge only.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_index=0, out_value=0, out_all_nan=0.
  - Internal counter and vector register are cleared to 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_vector, set best=element 0, best_idx=0, cnt=1.
  - Next state is SCAN if N>1, otherwise DONE.
- SCAN:
  - in_ready=0.
  - Each cycle compare element cnt against best; replace best and best_idx only if element cnt is strictly greater.
  - cnt increments; after element N-1 is compared, go to DONE.
- DONE:
  - out_valid=1; outputs stay stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Latency:
  - Accept in cycle 0; SCAN in cycles 1..N-1; out_valid visible in cycle N.
  - Minimum initiation interval is N+1 cycles with out_ready held high.
- Compare rules (fp32 greater-than):
  - Sign/magnitude ordering: positive > negative; larger magnitude wins among positives, smaller among negatives.
  - -0 and +0 are equal.
  - Infinities order normally.
  - Denormals are compared by bit pattern, with no flushing.
- Ties: the lowest index wins, because replacement requires strictly greater.
- NaN handling:
  - A NaN (exp=0xFF, mantissa!=0) never wins against a non-NaN.
  - A non-NaN always replaces a NaN best.
  - If all elements are NaN: out_index=0, out_value=element 0 bits, out_all_nan=1; otherwise out_all_nan=0.
- Register behaviour: in_vector is ignored outside IDLE; the registered copy is used for the whole scan.
- Reset mid-operation: rst in SCAN or DONE returns to IDLE with reset values next cycle; the in-flight result is dropped and no out_valid pulse is produced.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Shared package holds:
  - FP32_EXP_MAX = 8'hFF.
  - FP32_POS_ZERO and FP32_NEG_ZERO constants.
  - An is_nan function.
  - FSM state encoding constants (IDLE=0, SCAN=1, DONE=2).
- One sub-module: fp32_greater, combinational, inputs a and b (32 bits each), output a_gt_b.
  - It applies the ordering and NaN rules above.
  - It is reusable by later max-pool blocks.

Test Plan:
- Softmax output vector {0x3890969E, 0x39D53C13, 0x3D388CBF, 0x3F745809}, out_ready=1 -> out_valid in cycle 4, out_index=3, out_value=0x3F745809, out_all_nan=0.
- All-negative vector {0xC0000000(-2), 0xBF800000(-1), 0xC0800000(-4), 0xC0400000(-3)} -> out_index=1, out_value=0xBF800000.
- Tie and zero-sign vectors:
  - {0x3F800000, 0x3F800000, 0x3F000000, 0x3E800000} -> out_index=0.
  - {0x80000000, 0x00000000, 0xBF800000, 0xC0000000} -> out_index=0, out_value=0x80000000.
- NaN vectors:
  - {0x7FC00000, 0x3F000000, 0x7F800001, 0x3E800000} -> out_index=1, out_value=0x3F000000, out_all_nan=0.
  - All four elements 0x7FC00000 -> out_index=0, out_all_nan=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; a new in_valid is not accepted until the cycle after the out handshake.
- Reset mid-scan: assert rst in cycle 2 after acceptance -> next cycle in_ready=1, out_valid=0, out_index=0, out_value=0; no result is produced for the dropped vector.
